button_press_classifier: RTL and testbench
==========================================

Name: button_press_classifier

Overview:
- Downstream stage of the button debouncer, in the same 1 kHz clock domain (1 cycle = 1 ms).
- Consumes the debounced button signal and classifies each user gesture as a short, long or double press.
- Emits a single-cycle event pulse for each gesture and keeps a running event count for the LED/UART reporting logic.
- Tolerates a periodically re-asserted debounced signal during a hold by using a release-gap filter.

Parameters:
- LONG_MS, 1000: hold length in cycles that makes a long press.
- DOUBLE_MS, 300: maximum gap in cycles between release and second press for a double press.
- RELEASE_MS, 20: consecutive low cycles on btn_db required to declare release. Must exceed the maximum low gap of the upstream debounced output during a hold (16).
- CNT_W, 8: width of press_count.

Ports:
- clk_1k  input  1  1 kHz clock.
- rst  input  1  Asynchronous, active-high reset; driven from !locked of the Clocking Wizard.
- btn_db  input  1  Debounced button; high = pressed.
- short_press  output  1  One-cycle pulse: single short press classified.
- long_press  output  1  One-cycle pulse: hold reached LONG_MS.
- double_press  output  1  One-cycle pulse: two presses within DOUBLE_MS.
- press_count  output  CNT_W  Number of classified events, wraps modulo 2^CNT_W.
- busy  output  1  High whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all timers 0, all outputs 0, press_count=0.
  - Reset mid-gesture discards the gesture; no pulse is emitted after reset deasserts.
- Registers:
  - tmr: width clog2(max(LONG_MS,DOUBLE_MS)+1), saturating.
  - gap: width clog2(RELEASE_MS+1), clears on any btn_db=1.
  - All outputs are registered.
- "Released" means gap reaches RELEASE_MS at this edge.
- IDLE:
  - btn_db=1 -> PRESS1, tmr=1.
- PRESS1:
  - tmr increments every cycle, high or low.
  - tmr reaches LONG_MS -> long_press=1 next cycle, go LONG_HOLD. Long has priority over a release completing on the same edge.
  - Released (tmr<LONG_MS) -> WAIT2, tmr=0.
- LONG_HOLD:
  - Released -> IDLE.
  - No further pulses regardless of hold length.
- WAIT2:
  - tmr increments.
  - btn_db=1 -> PRESS2. Checked before the timeout, so a press on the timeout edge counts as a double press.
  - Else tmr reaches DOUBLE_MS -> short_press pulse, go IDLE.
- PRESS2:
  - Released -> double_press pulse, go IDLE.
  - Hold length is irrelevant; no long_press is generated from PRESS2.
- Outputs:
  - Each pulse is exactly 1 cycle, and at most one pulse is asserted per cycle.
  - press_count increments by 1 in the same cycle any pulse is asserted; it wraps from 2^CNT_W-1 to 0.
  - busy is combinationally equal to (state != IDLE); it is the only non-registered output.
- Latencies, with the press first sampled at edge E:
  - long_press high in the cycle after edge E+LONG_MS-1.
  - Short press:
    - Last high sample at edge R; release declared at R+RELEASE_MS.
    - short_press follows DOUBLE_MS cycles later.
- btn_db held continuously high out of reset: treated as a press starting at the first sampled edge.

Test Plan:
1. btn_db high 100 cycles, then low -> exactly one short_press, 20+300 cycles after the last high sample (±1 cycle per the latency rule above); press_count=1; busy low afterwards.
2. btn_db high 1200 cycles, then low -> long_press once, 1000 cycles after the first high; no short_press on release; busy drops 20 cycles after release; press_count=1.
3. high 100, low 100, high 100, low -> one double_press, 20 cycles after the second release; no short_press; press_count=1.
4. btn_db a 1-cycle pulse every 16 cycles for 480 cycles, then low -> classified as one hold with exactly one short_press. The same pattern for 1200 cycles -> exactly one long_press.
5. Second press boundary: release declared; the next press lands at WAIT2 tmr=DOUBLE_MS -> double_press. The same press at DOUBLE_MS+1 -> short_press, then a new PRESS1 sequence.
6. rst pulsed at cycle 500 of a hold -> all outputs 0 and press_count=0 immediately. After releasing the button, no pulse occurs. Also run 256 short presses -> press_count wraps to 0.

Source files
------------

// File: rtl/button_press_classifier_if.sv
`timescale 1ns/1ps
// Bundle between the debouncer-side stimulus and the press classifier.
// The master drives the debounced button; the slave returns events and count.
interface button_press_classifier_if #(
  parameter int CNT_W = 8
);
  logic             btn_db;
  logic             short_press;
  logic             long_press;
  logic             double_press;
  logic [CNT_W-1:0] press_count;
  logic             busy;

  modport master (
    output btn_db,
    input  short_press, long_press, double_press, press_count, busy
  );

  modport slave (
    input  btn_db,
    output short_press, long_press, double_press, press_count, busy
  );
endinterface

// File: rtl/button_press_classifier.sv
`timescale 1ns/1ps
// Classifies debounced button gestures (1 cycle = 1 ms) into short, long and
// double presses, emitting one-cycle event pulses and a wrapping event count.
module button_press_classifier #(
  parameter int LONG_MS    = 1000,
  parameter int DOUBLE_MS  = 300,
  parameter int RELEASE_MS = 20,
  parameter int CNT_W      = 8
) (
  input logic                      clk_1k,
  input logic                      rst,
  button_press_classifier_if.slave bus
);
  localparam int TMR_MAX = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int GAP_W   = $clog2(RELEASE_MS + 1);

  localparam logic [TMR_W-1:0] TMR_SAT     = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0] LONG_LAST   = TMR_W'(LONG_MS - 1);
  localparam logic [TMR_W-1:0] DOUBLE_LAST = TMR_W'(DOUBLE_MS - 1);
  localparam logic [GAP_W-1:0] GAP_SAT     = GAP_W'(RELEASE_MS);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(RELEASE_MS - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HOLD, WAIT2, PRESS2} state_t;

  state_t           r_state, w_stateNext;
  logic [TMR_W-1:0] r_tmr, w_tmrNext, w_tmrInc;
  logic [GAP_W-1:0] r_gap, w_gapNext;
  logic             r_short, r_long, r_double;
  logic             w_shortNext, w_longNext, w_doubleNext;
  logic [CNT_W-1:0] r_count, w_countNext;
  logic             w_released;

  // The gap filter bridges the short low dips the debouncer shows during a hold.
  assign w_gapNext  = bus.btn_db ? '0 : ((r_gap == GAP_SAT) ? r_gap : r_gap + 1'b1);
  assign w_released = !bus.btn_db && (r_gap == GAP_LAST);
  assign w_tmrInc   = (r_tmr == TMR_SAT) ? r_tmr : r_tmr + 1'b1;

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tmr    <= '0;
      r_gap    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_tmr    <= w_tmrNext;
      r_gap    <= w_gapNext;
      r_short  <= w_shortNext;
      r_long   <= w_longNext;
      r_double <= w_doubleNext;
      r_count  <= w_countNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_tmrNext    = r_tmr;
    w_shortNext  = 1'b0;
    w_longNext   = 1'b0;
    w_doubleNext = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmrNext = '0;
        if (bus.btn_db) begin
          w_stateNext = PRESS1;
          w_tmrNext   = TMR_W'(1);
        end
      end
      PRESS1: begin
        w_tmrNext = w_tmrInc;
        // Reaching the long threshold wins over a release completing on the same edge.
        if (r_tmr == LONG_LAST) begin
          w_longNext  = 1'b1;
          w_stateNext = LONG_HOLD;
        end else if (w_released) begin
          w_stateNext = WAIT2;
          w_tmrNext   = '0;
        end
      end
      LONG_HOLD: begin
        if (w_released) begin
          w_stateNext = IDLE;
          w_tmrNext   = '0;
        end
      end
      WAIT2: begin
        w_tmrNext = w_tmrInc;
        if (bus.btn_db) begin
          w_stateNext = PRESS2;
          w_tmrNext   = '0;
        end else if (r_tmr == DOUBLE_LAST) begin
          w_shortNext = 1'b1;
          w_stateNext = IDLE;
          w_tmrNext   = '0;
        end
      end
      PRESS2: begin
        w_tmrNext = '0;
        if (w_released) begin
          w_doubleNext = 1'b1;
          w_stateNext  = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_tmrNext   = '0;
      end
    endcase
    w_countNext = (w_shortNext || w_longNext || w_doubleNext) ? r_count + 1'b1 : r_count;
  end

  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.double_press = r_double;
  assign bus.press_count  = r_count;
  assign bus.busy         = (r_state != IDLE);
endmodule

// File: tb/tb_button_press_classifier.sv
`timescale 1ns/1ps
// Directed bench for button_press_classifier: a full-size instance for gesture
// timing and a small-parameter instance for the press_count wrap.
module tb_button_press_classifier;
  localparam int CNT_W = 8;

  logic clk_1k = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int nShort = 0, nLong = 0, nDouble = 0, nMulti = 0;
  int nFastShort = 0, nFastOther = 0;
  int lastShortEdge = -1, lastLongEdge = -1, lastDoubleEdge = -1;
  int baseShort, baseLong, baseDouble, baseFastShort;
  int s, r, r2;

  button_press_classifier_if #(.CNT_W(CNT_W)) busMain ();
  button_press_classifier_if #(.CNT_W(CNT_W)) busFast ();

  button_press_classifier #(
    .LONG_MS(1000), .DOUBLE_MS(300), .RELEASE_MS(20), .CNT_W(CNT_W)
  ) u_dut (
    .clk_1k(clk_1k), .rst(rst), .bus(busMain.slave)
  );

  button_press_classifier #(
    .LONG_MS(40), .DOUBLE_MS(10), .RELEASE_MS(4), .CNT_W(CNT_W)
  ) u_dutFast (
    .clk_1k(clk_1k), .rst(rst), .bus(busFast.slave)
  );

  always #5 clk_1k = ~clk_1k;

  always @(posedge clk_1k) cyc <= cyc + 1;

  // Pulse monitor: sampled 1 ns after the edge, cyc then names the edge that registered it.
  always begin
    @(posedge clk_1k);
    #1;
    if (busMain.short_press)  begin nShort++;  lastShortEdge  = cyc; end
    if (busMain.long_press)   begin nLong++;   lastLongEdge   = cyc; end
    if (busMain.double_press) begin nDouble++; lastDoubleEdge = cyc; end
    if (32'(busMain.short_press) + 32'(busMain.long_press) + 32'(busMain.double_press) > 1) nMulti++;
    if (busFast.short_press) nFastShort++;
    if (busFast.long_press || busFast.double_press) nFastOther++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit fast, input logic level, input int n);
    if (fast) busFast.btn_db = level;
    else      busMain.btn_db = level;
    repeat (n) @(negedge clk_1k);
  endtask

  task automatic snap();
    baseShort     = nShort;
    baseLong      = nLong;
    baseDouble    = nDouble;
    baseFastShort = nFastShort;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk_1k);
    rst = 1'b0;
    @(negedge clk_1k);
  endtask

  initial begin
    rst = 1'b1;
    busMain.btn_db = 1'b0;
    busFast.btn_db = 1'b0;
    repeat (3) @(negedge clk_1k);
    checkOutput("rst_short",  32'(busMain.short_press), 0);
    checkOutput("rst_long",   32'(busMain.long_press), 0);
    checkOutput("rst_double", 32'(busMain.double_press), 0);
    checkOutput("rst_count",  32'(busMain.press_count), 0);
    checkOutput("rst_busy",   32'(busMain.busy), 0);
    rst = 1'b0;
    @(negedge clk_1k);

    $display("[TB] short press");
    snap(); s = cyc;
    applyStimulus(0, 1'b1, 100);
    checkOutput("t1_busy_hold", 32'(busMain.busy), 1);
    r = cyc;
    applyStimulus(0, 1'b0, 400);
    checkOutput("t1_short_n",    32'(nShort - baseShort), 1);
    checkOutput("t1_short_edge", 32'(lastShortEdge), 32'(r + 320));
    checkOutput("t1_long_n",     32'(nLong - baseLong), 0);
    checkOutput("t1_double_n",   32'(nDouble - baseDouble), 0);
    checkOutput("t1_count",      32'(busMain.press_count), 1);
    checkOutput("t1_busy_end",   32'(busMain.busy), 0);

    $display("[TB] long press");
    doReset(); snap(); s = cyc;
    applyStimulus(0, 1'b1, 1200);
    checkOutput("t2_long_n",    32'(nLong - baseLong), 1);
    checkOutput("t2_long_edge", 32'(lastLongEdge), 32'(s + 1000));
    r = cyc;
    applyStimulus(0, 1'b0, 19);
    checkOutput("t2_busy_r19", 32'(busMain.busy), 1);
    applyStimulus(0, 1'b0, 1);
    checkOutput("t2_busy_r20", 32'(busMain.busy), 0);
    applyStimulus(0, 1'b0, 400);
    checkOutput("t2_short_n",  32'(nShort - baseShort), 0);
    checkOutput("t2_long_n2",  32'(nLong - baseLong), 1);
    checkOutput("t2_count",    32'(busMain.press_count), 1);

    $display("[TB] double press");
    doReset(); snap(); s = cyc;
    applyStimulus(0, 1'b1, 100);
    applyStimulus(0, 1'b0, 100);
    applyStimulus(0, 1'b1, 100);
    r = cyc;
    applyStimulus(0, 1'b0, 20);
    checkOutput("t3_double_n",    32'(nDouble - baseDouble), 1);
    checkOutput("t3_double_edge", 32'(lastDoubleEdge), 32'(r + 20));
    checkOutput("t3_busy_end",    32'(busMain.busy), 0);
    applyStimulus(0, 1'b0, 400);
    checkOutput("t3_short_n", 32'(nShort - baseShort), 0);
    checkOutput("t3_count",   32'(busMain.press_count), 1);

    $display("[TB] chattering hold");
    doReset(); snap(); s = cyc;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 1'b1, 1);
      applyStimulus(0, 1'b0, 15);
    end
    applyStimulus(0, 1'b0, 400);
    checkOutput("t4a_short_n",    32'(nShort - baseShort), 1);
    checkOutput("t4a_short_edge", 32'(lastShortEdge), 32'(s + 465 + 320));
    checkOutput("t4a_long_n",     32'(nLong - baseLong), 0);
    checkOutput("t4a_double_n",   32'(nDouble - baseDouble), 0);
    checkOutput("t4a_count",      32'(busMain.press_count), 1);

    doReset(); snap(); s = cyc;
    for (int i = 0; i < 75; i++) begin
      applyStimulus(0, 1'b1, 1);
      applyStimulus(0, 1'b0, 15);
    end
    applyStimulus(0, 1'b0, 400);
    checkOutput("t4b_long_n",    32'(nLong - baseLong), 1);
    checkOutput("t4b_long_edge", 32'(lastLongEdge), 32'(s + 1000));
    checkOutput("t4b_short_n",   32'(nShort - baseShort), 0);
    checkOutput("t4b_count",     32'(busMain.press_count), 1);
    checkOutput("t4b_busy_end",  32'(busMain.busy), 0);

    $display("[TB] second press boundary");
    doReset(); snap();
    applyStimulus(0, 1'b1, 100);
    applyStimulus(0, 1'b0, 319);
    applyStimulus(0, 1'b1, 50);
    r2 = cyc;
    applyStimulus(0, 1'b0, 400);
    checkOutput("t5a_double_n",    32'(nDouble - baseDouble), 1);
    checkOutput("t5a_double_edge", 32'(lastDoubleEdge), 32'(r2 + 20));
    checkOutput("t5a_short_n",     32'(nShort - baseShort), 0);
    checkOutput("t5a_count",       32'(busMain.press_count), 1);

    doReset(); snap();
    applyStimulus(0, 1'b1, 100);
    r = cyc;
    applyStimulus(0, 1'b0, 320);
    checkOutput("t5b_short_n1",    32'(nShort - baseShort), 1);
    checkOutput("t5b_short_edge1", 32'(lastShortEdge), 32'(r + 320));
    checkOutput("t5b_busy_gap",    32'(busMain.busy), 0);
    applyStimulus(0, 1'b1, 50);
    checkOutput("t5b_busy_new",    32'(busMain.busy), 1);
    r2 = cyc;
    applyStimulus(0, 1'b0, 400);
    checkOutput("t5b_short_n2",    32'(nShort - baseShort), 2);
    checkOutput("t5b_short_edge2", 32'(lastShortEdge), 32'(r2 + 320));
    checkOutput("t5b_double_n",    32'(nDouble - baseDouble), 0);
    checkOutput("t5b_count",       32'(busMain.press_count), 2);

    $display("[TB] reset mid-hold");
    doReset();
    applyStimulus(0, 1'b1, 10);
    applyStimulus(0, 1'b0, 400);
    checkOutput("t6_count_pre", 32'(busMain.press_count), 1);
    applyStimulus(0, 1'b1, 500);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_short",  32'(busMain.short_press), 0);
    checkOutput("t6_rst_long",   32'(busMain.long_press), 0);
    checkOutput("t6_rst_double", 32'(busMain.double_press), 0);
    checkOutput("t6_rst_count",  32'(busMain.press_count), 0);
    checkOutput("t6_rst_busy",   32'(busMain.busy), 0);
    repeat (2) @(negedge clk_1k);
    busMain.btn_db = 1'b0;
    @(negedge clk_1k);
    rst = 1'b0;
    snap();
    applyStimulus(0, 1'b0, 500);
    checkOutput("t6_post_short",  32'(nShort - baseShort), 0);
    checkOutput("t6_post_long",   32'(nLong - baseLong), 0);
    checkOutput("t6_post_double", 32'(nDouble - baseDouble), 0);
    checkOutput("t6_post_count",  32'(busMain.press_count), 0);

    $display("[TB] press_count wrap");
    doReset(); snap();
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1, 1'b1, 3);
      applyStimulus(1, 1'b0, 17);
    end
    checkOutput("wrap_count_255", 32'(busFast.press_count), 255);
    applyStimulus(1, 1'b1, 3);
    applyStimulus(1, 1'b0, 17);
    checkOutput("wrap_count_0",  32'(busFast.press_count), 0);
    checkOutput("wrap_short_n",  32'(nFastShort - baseFastShort), 256);
    checkOutput("wrap_other_n",  32'(nFastOther), 0);
    checkOutput("one_hot_pulse", 32'(nMulti), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
